// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for the single combinational instruction-ROM read port.
// Fetch (IF) and debug (DBG) share the port; a halt sequencer can stop fetch cleanly.
module rom_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_valid,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_req_ready,
  input  logic          if_flush,
  output logic          if_resp_valid,
  output logic [DW-1:0] if_resp_data,
  input  logic          dbg_req_valid,
  input  logic [AW-1:0] dbg_req_addr,
  output logic          dbg_req_ready,
  output logic          dbg_resp_valid,
  output logic [DW-1:0] dbg_resp_data,
  input  logic          dbg_halt_req,
  output logic          halted,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic          if_resp_valid_q, dbg_resp_valid_q;
  logic [DW-1:0] if_resp_data_q, dbg_resp_data_q;

  logic fetch_ok;
  logic force_dbg;
  logic dbg_grant;
  logic if_grant;

  // Grant decision and next-state logic.
  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    last_addr_d = last_addr_q;
    rom_addr    = last_addr_q;

    fetch_ok  = (state_q == RUN) && !if_flush;
    force_dbg = (wait_cnt_q == LIMIT) || (state_q != RUN);
    dbg_grant = dbg_req_valid && (force_dbg || !(if_req_valid && fetch_ok));
    if_grant  = !dbg_grant && if_req_valid && fetch_ok;

    if (dbg_grant) begin
      rom_addr    = dbg_req_addr;
      last_addr_d = dbg_req_addr;
    end else if (if_grant) begin
      rom_addr    = if_req_addr;
      last_addr_d = if_req_addr;
    end

    // DBG can only lose to an IF grant, so this covers every case.
    if (!dbg_req_valid || dbg_grant) begin
      wait_cnt_d = '0;
    end else if (if_grant && (wait_cnt_q < LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    unique case (state_q)
      RUN:     if (dbg_halt_req)  state_d = DRAIN;
      DRAIN:   state_d = dbg_halt_req ? HALTED : RUN;
      HALTED:  if (!dbg_halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      wait_cnt_q       <= '0;
      last_addr_q      <= '0;
      if_resp_valid_q  <= 1'b0;
      dbg_resp_valid_q <= 1'b0;
      if_resp_data_q   <= '0;
      dbg_resp_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      last_addr_q      <= last_addr_d;
      if_resp_valid_q  <= if_grant;
      dbg_resp_valid_q <= dbg_grant;
      if (if_grant)  if_resp_data_q  <= rom_data;
      if (dbg_grant) dbg_resp_data_q <= rom_data;
    end
  end

  assign if_req_ready   = if_grant;
  assign dbg_req_ready  = dbg_grant;
  // A flush in the response cycle squashes the pending fetch word.
  assign if_resp_valid  = if_resp_valid_q && !if_flush;
  assign if_resp_data   = if_resp_data_q;
  assign dbg_resp_valid = dbg_resp_valid_q;
  assign dbg_resp_data  = dbg_resp_data_q;
  assign halted         = (state_q == HALTED);

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction-ROM read port (16-bit address, 32-bit word) between two requesters: the pipeline fetch stage (port IF) and the debug/loader reader (port DBG).
- Arbitrates once per cycle, drives the ROM address, and registers the returned word into the winner's response register.
- Provides a debug halt sequencer that stops fetch grants cleanly.
- Sits between the fetch stage and the ROM.

Parameters:
- AW, 16, ROM address width.
- DW, 32, ROM data width.
- STARVE_LIMIT, 4, consecutive DBG losses before DBG is forced to win; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- if_req_valid  input  1  fetch requests a ROM read this cycle.
- if_req_addr  input  AW  fetch word address.
- if_req_ready  output  1  fetch request granted this cycle (combinational).
- if_flush  input  1  branch flush; cancels fetch grant and pending fetch response.
- if_resp_valid  output  1  if_resp_data valid; one-cycle pulse, no backpressure.
- if_resp_data  output  DW  registered ROM word for fetch.
- dbg_req_valid  input  1  debug requests a ROM read.
- dbg_req_addr  input  AW  debug word address.
- dbg_req_ready  output  1  debug request granted this cycle (combinational).
- dbg_resp_valid  output  1  dbg_resp_data valid; one-cycle pulse.
- dbg_resp_data  output  DW  registered ROM word for debug.
- dbg_halt_req  input  1  level request to halt fetch access.
- halted  output  1  high while in HALTED state.
- rom_addr  output  AW  address to ROM.
- rom_data  input  DW  combinational ROM output for rom_addr.

Behaviour:
- Reset values (async on rst_n low):
  - state=RUN, wait_cnt=0, last_addr=0.
  - if_resp_valid=0, dbg_resp_valid=0, if_resp_data=0, dbg_resp_data=0, halted=0.
- Reset mid-operation discards any grant and pending response; no response pulse follows reset release.
- FSM states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when dbg_halt_req=1.
  - DRAIN -> HALTED on the next cycle. The one-cycle latency means any fetch response from the last RUN grant is delivered during DRAIN.
  - HALTED -> RUN when dbg_halt_req=0. If dbg_halt_req drops while in DRAIN, go to RUN.
  - halted = (state==HALTED).
- fetch_ok = (state==RUN) && !if_flush.
- Grant rule, per cycle:
  - force_dbg = (wait_cnt==STARVE_LIMIT) || state!=RUN.
  - If dbg_req_valid && (force_dbg || !(if_req_valid && fetch_ok)), DBG wins.
  - Else if if_req_valid && fetch_ok, IF wins.
  - Else no grant.
  - At most one ready high per cycle.
- rom_addr = winner's address when granted, else last_addr. last_addr is updated to the granted address on each grant.
- Latency:
  - A grant in cycle N captures rom_data at the end of cycle N into the winner's data register.
  - The winner's resp_valid is high in cycle N+1 only.
  - A non-winner's data register holds its value.
- Back-to-back grants to the same port give consecutive resp_valid pulses. The consumer must accept every pulse; there is no stall path.
- if_flush:
  - In cycle N, if_flush forces if_req_ready=0.
  - It also forces if_resp_valid=0 in cycle N.
  - It does not affect DBG.
- Starvation counter wait_cnt (4 bits):
  - Increments when dbg_req_valid=1 and IF is granted.
  - Clears to 0 on a DBG grant or when dbg_req_valid=0.
  - Saturates at STARVE_LIMIT and never wraps.
- Simultaneous dbg_halt_req and if_req in RUN: this cycle is still RUN, so IF may win. The halt takes effect from the next cycle.

Test Plan:
- Reset then single fetch: rst_n low 2 cycles, check all outputs 0. Then if_req_valid=1, addr=0x0001 with ROM word 0x8B000022 -> if_req_ready=1 that cycle, rom_addr=0x0001, if_resp_valid=1 with data 0x8B000022 next cycle only.
- Starvation: both ports request continuously, STARVE_LIMIT=4 -> IF granted 4 cycles, DBG granted cycle 5, wait_cnt back to 0, IF granted cycle 6; repeating pattern 4:1.
- Flush: fetch granted in cycle N, if_flush=1 in cycle N+1 -> if_resp_valid=0 in N+1, if_req_ready=0 in N+1; DBG request in N+1 granted.
- Halt sequence: fetch streaming, dbg_halt_req=1 at cycle N -> last IF grant at N, if_resp_valid at N+1 (DRAIN), halted=1 from N+2. IF requests are ignored while DBG reads addr 0x0003 and returns 0xF8000083. dbg_halt_req=0 -> RUN next cycle, fetch resumes.
- Idle address hold: after DBG read of 0x0002, no requests for 5 cycles -> rom_addr stays 0x0002, no resp_valid pulses.
- Async reset mid-grant: rst_n low mid-cycle during an IF grant -> if_resp_valid never pulses, state RUN, halted=0 immediately.
